// File: rtl/reg_file_exec_ctrl_pkg.sv
// Shared definitions for the register-file execute/writeback controller.
// Holds the opcode and FSM state encodings and the default data and address widths.
package reg_file_exec_defs;

  localparam int DEF_DATA_W = 9;
  localparam int DEF_ADDR_W = 2;

  typedef enum logic [2:0] {
    OP_NOP = 3'd0,
    OP_ADD = 3'd1,
    OP_SUB = 3'd2,
    OP_AND = 3'd3,
    OP_OR  = 3'd4,
    OP_XOR = 3'd5,
    OP_MOV = 3'd6,
    OP_LDI = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_EXEC = 2'd2,
    ST_WB   = 2'd3
  } state_e;

endpackage

// File: rtl/reg_file_exec_alu.sv
// Combinational ALU: result plus carry/borrow, zero cycles, no handshake.
// SAT_ARITH_EN clamps ADD overflow to all-ones and SUB underflow to zero.
module reg_file_exec_alu
  import reg_file_exec_defs::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  op_e               op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] imm,
  output logic [DATA_W-1:0] result,
  output logic              carry
);

  logic [DATA_W:0] sum;
  logic [DATA_W:0] diff;

  assign sum  = {1'b0, a} + {1'b0, b};
  // Top bit of the extended difference is the borrow, i.e. a < b.
  assign diff = {1'b0, a} - {1'b0, b};

  always_comb begin
    result = '0;
    carry  = 1'b0;
    case (op)
      OP_ADD: begin
        carry = sum[DATA_W];
`ifdef SAT_ARITH_EN
        result = sum[DATA_W] ? '1 : sum[DATA_W-1:0];
`else
        result = sum[DATA_W-1:0];
`endif
      end
      OP_SUB: begin
        carry = diff[DATA_W];
`ifdef SAT_ARITH_EN
        result = diff[DATA_W] ? '0 : diff[DATA_W-1:0];
`else
        result = diff[DATA_W-1:0];
`endif
      end
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_MOV:  result = a;
      OP_LDI:  result = imm;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/reg_file_exec_ctrl.sv
// Execute/writeback controller and sole write master of the 4x9 register file; 4 cycles/instr.
// Accepts on valid&ready in IDLE only (source holds valid); SAT_ARITH_EN selects saturating ALU.
module reg_file_exec_ctrl
  import reg_file_exec_defs::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [2:0]        instr_op,
  input  logic [ADDR_W-1:0] instr_dst,
  input  logic [ADDR_W-1:0] instr_src0,
  input  logic [ADDR_W-1:0] instr_src1,
  input  logic [DATA_W-1:0] instr_imm,
  output logic [ADDR_W-1:0] rd0_addr,
  output logic [ADDR_W-1:0] rd1_addr,
  input  logic [DATA_W-1:0] rd0_data,
  input  logic [DATA_W-1:0] rd1_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              flag_z,
  output logic              flag_c
);

  state_e            state_q;
  state_e            state_d;
  op_e               op_q;
  logic [ADDR_W-1:0] dst_q;
  logic [DATA_W-1:0] imm_q;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic [DATA_W-1:0] alu_result;
  logic              alu_carry;
  logic              accept;

  assign accept = instr_valid & instr_ready & (state_q == ST_IDLE);
  assign busy   = (state_q != ST_IDLE);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_READ;
      ST_READ: state_d = ST_EXEC;
      ST_EXEC: state_d = ST_WB;
      ST_WB:   state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  reg_file_exec_alu #(.DATA_W(DATA_W)) u_alu (
    .op     (op_q),
    .a      (a_q),
    .b      (b_q),
    .imm    (imm_q),
    .result (alu_result),
    .carry  (alu_carry)
  );

  // Ready is registered so it stays low throughout reset and rises one edge after release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      instr_ready <= 1'b0;
      op_q        <= OP_NOP;
      dst_q       <= '0;
      imm_q       <= '0;
      rd0_addr    <= '0;
      rd1_addr    <= '0;
      a_q         <= '0;
      b_q         <= '0;
      wr_en       <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      flag_z      <= 1'b0;
      flag_c      <= 1'b0;
    end else begin
      instr_ready <= (state_d == ST_IDLE);
      wr_en       <= 1'b0;
      if (accept) begin
        op_q     <= op_e'(instr_op);
        dst_q    <= instr_dst;
        imm_q    <= instr_imm;
        rd0_addr <= instr_src0;
        rd1_addr <= instr_src1;
      end
      if (state_q == ST_READ) begin
        a_q <= rd0_data;
        b_q <= rd1_data;
      end
      // NOP skips both the write and the flag update.
      if (state_q == ST_EXEC && op_q != OP_NOP) begin
        wr_en   <= 1'b1;
        wr_addr <= dst_q;
        wr_data <= alu_result;
        flag_z  <= (alu_result == '0);
        flag_c  <= alu_carry;
      end
    end
  end

endmodule

// File: tb/tb_reg_file_exec_ctrl.sv
// Directed bench: controller plus a behavioural 4x9 register file writing on negedge.
module tb_reg_file_exec_ctrl;

  logic       clk;
  logic       rst;
  logic       instr_valid;
  logic       instr_ready;
  logic [2:0] instr_op;
  logic [1:0] instr_dst;
  logic [1:0] instr_src0;
  logic [1:0] instr_src1;
  logic [8:0] instr_imm;
  logic [1:0] rd0_addr;
  logic [1:0] rd1_addr;
  logic [8:0] rd0_data;
  logic [8:0] rd1_data;
  logic       wr_en;
  logic [1:0] wr_addr;
  logic [8:0] wr_data;
  logic       busy;
  logic       flag_z;
  logic       flag_c;

  int compared = 0;
  int mismatched = 0;

  logic [8:0] rf [4];
  logic       rf_rst;

  assign rf_rst   = ~rst;
  assign rd0_data = rf[rd0_addr];
  assign rd1_data = rf[rd1_addr];

  always @(negedge clk or posedge rf_rst) begin
    if (rf_rst) begin
      for (int i = 0; i < 4; i++) rf[i] <= '0;
    end else if (wr_en) begin
      rf[wr_addr] <= wr_data;
    end
  end

  reg_file_exec_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr_op    (instr_op),
    .instr_dst   (instr_dst),
    .instr_src0  (instr_src0),
    .instr_src1  (instr_src1),
    .instr_imm   (instr_imm),
    .rd0_addr    (rd0_addr),
    .rd1_addr    (rd1_addr),
    .rd0_data    (rd0_data),
    .rd1_data    (rd1_data),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .busy        (busy),
    .flag_z      (flag_z),
    .flag_c      (flag_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

`ifdef SAT_ARITH_EN
  localparam logic [8:0] ADD_OVF_D = 9'd511;
  localparam logic [8:0] SUB_UNF_D = 9'd0;
  localparam logic       SUB_UNF_Z = 1'b1;
`else
  localparam logic [8:0] ADD_OVF_D = 9'd1;
  localparam logic [8:0] SUB_UNF_D = 9'd408;
  localparam logic       SUB_UNF_Z = 1'b0;
`endif

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (instr_ready !== 1'b1 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("ready_wait", {15'd0, instr_ready}, 16'd1);
  endtask

  task automatic drive(input logic [2:0] op, input logic [1:0] dst, input logic [1:0] s0,
                       input logic [1:0] s1, input logic [8:0] imm);
    instr_valid = 1'b1;
    instr_op    = op;
    instr_dst   = dst;
    instr_src0  = s0;
    instr_src1  = s1;
    instr_imm   = imm;
  endtask

  // Issues one instruction and checks every cycle up to the return to IDLE.
  task automatic run_instr(input string nm, input logic [2:0] op, input logic [1:0] dst,
                           input logic [1:0] s0, input logic [1:0] s1, input logic [8:0] imm,
                           input logic exp_we, input logic [8:0] exp_d,
                           input logic exp_z, input logic exp_c);
    wait_ready();
    drive(op, dst, s0, s1, imm);
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    check({nm, ".read_rdy"}, {15'd0, instr_ready}, 16'd0);
    check({nm, ".read_busy"}, {15'd0, busy}, 16'd1);
    check({nm, ".rd0_addr"}, {14'd0, rd0_addr}, {14'd0, s0});
    check({nm, ".rd1_addr"}, {14'd0, rd1_addr}, {14'd0, s1});
    @(posedge clk);
    #1;
    check({nm, ".exec_rdy"}, {15'd0, instr_ready}, 16'd0);
    check({nm, ".exec_we"}, {15'd0, wr_en}, 16'd0);
    @(posedge clk);
    #1;
    check({nm, ".wb_rdy"}, {15'd0, instr_ready}, 16'd0);
    check({nm, ".wb_we"}, {15'd0, wr_en}, {15'd0, exp_we});
    check({nm, ".flag_z"}, {15'd0, flag_z}, {15'd0, exp_z});
    check({nm, ".flag_c"}, {15'd0, flag_c}, {15'd0, exp_c});
    if (exp_we) begin
      check({nm, ".wr_addr"}, {14'd0, wr_addr}, {14'd0, dst});
      check({nm, ".wr_data"}, {7'd0, wr_data}, {7'd0, exp_d});
      @(negedge clk);
      #1;
      check({nm, ".rf_commit"}, {7'd0, rf[dst]}, {7'd0, exp_d});
    end
    @(posedge clk);
    #1;
    check({nm, ".idle_we"}, {15'd0, wr_en}, 16'd0);
    check({nm, ".idle_rdy"}, {15'd0, instr_ready}, 16'd1);
    check({nm, ".idle_busy"}, {15'd0, busy}, 16'd0);
  endtask

  initial begin
    rst = 1'b0;
    drive(3'd0, 2'd0, 2'd0, 2'd0, 9'd0);
    instr_valid = 1'b0;
    #3;
    check("rst.ready", {15'd0, instr_ready}, 16'd0);
    check("rst.busy", {15'd0, busy}, 16'd0);
    check("rst.wr_en", {15'd0, wr_en}, 16'd0);
    check("rst.wr_addr", {14'd0, wr_addr}, 16'd0);
    check("rst.wr_data", {7'd0, wr_data}, 16'd0);
    check("rst.rd0_addr", {14'd0, rd0_addr}, 16'd0);
    check("rst.rd1_addr", {14'd0, rd1_addr}, 16'd0);
    check("rst.flag_z", {15'd0, flag_z}, 16'd0);
    check("rst.flag_c", {15'd0, flag_c}, 16'd0);
    repeat (2) @(posedge clk);
    #1;
    check("rst.ready_held", {15'd0, instr_ready}, 16'd0);
    rst = 1'b1;
    #1;
    check("rel.ready_pre_edge", {15'd0, instr_ready}, 16'd0);
    @(posedge clk);
    #1;
    check("rel.ready", {15'd0, instr_ready}, 16'd1);

    //          name     op    dst   s0    s1    imm      we    data       z          c
    run_instr("ldi_r1",  3'd7, 2'd1, 2'd0, 2'd0, 9'd13,  1'b1, 9'd13,     1'b0,      1'b0);
    run_instr("ldi_r0",  3'd7, 2'd0, 2'd0, 2'd0, 9'd117, 1'b1, 9'd117,    1'b0,      1'b0);
    run_instr("add_raw", 3'd1, 2'd2, 2'd0, 2'd1, 9'd0,   1'b1, 9'd130,    1'b0,      1'b0);
    run_instr("ldi_r3",  3'd7, 2'd3, 2'd0, 2'd0, 9'd500, 1'b1, 9'd500,    1'b0,      1'b0);
    run_instr("add_ovf", 3'd1, 2'd3, 2'd3, 2'd1, 9'd0,   1'b1, ADD_OVF_D, 1'b0,      1'b1);
    run_instr("sub_unf", 3'd2, 2'd2, 2'd1, 2'd0, 9'd0,   1'b1, SUB_UNF_D, SUB_UNF_Z, 1'b1);
    run_instr("xor_0",   3'd5, 2'd1, 2'd1, 2'd1, 9'd0,   1'b1, 9'd0,      1'b1,      1'b0);
    run_instr("nop",     3'd0, 2'd3, 2'd2, 2'd0, 9'd99,  1'b0, 9'd0,      1'b1,      1'b0);

    // Reset lands in the EXEC cycle of ADD r0,r0,r1.
    wait_ready();
    drive(3'd1, 2'd0, 2'd0, 2'd1, 9'd0);
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    @(posedge clk);
    #1;
    check("mid.in_exec", {15'd0, busy}, 16'd1);
    rst = 1'b0;
    #1;
    check("mid.wr_en", {15'd0, wr_en}, 16'd0);
    check("mid.busy", {15'd0, busy}, 16'd0);
    check("mid.ready", {15'd0, instr_ready}, 16'd0);
    check("mid.flag_z", {15'd0, flag_z}, 16'd0);
    check("mid.flag_c", {15'd0, flag_c}, 16'd0);
    for (int i = 0; i < 4; i++) check("mid.rf_clear", {7'd0, rf[i]}, 16'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("mid.wr_en_held", {15'd0, wr_en}, 16'd0);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("post.ready", {15'd0, instr_ready}, 16'd1);
    check("post.busy", {15'd0, busy}, 16'd0);
    check("post.flag_z", {15'd0, flag_z}, 16'd0);
    check("post.flag_c", {15'd0, flag_c}, 16'd0);
    check("post.rf0", {7'd0, rf[0]}, 16'd0);

    // Valid held high across the whole instruction is taken only once.
    drive(3'd7, 2'd2, 2'd0, 2'd0, 9'd77);
    @(posedge clk);
    #1;
    check("hold.busy_e0", {15'd0, busy}, 16'd1);
    @(posedge clk);
    #1;
    check("hold.we_e1", {15'd0, wr_en}, 16'd0);
    @(posedge clk);
    #1;
    check("hold.we_e2", {15'd0, wr_en}, 16'd1);
    check("hold.wr_addr", {14'd0, wr_addr}, 16'd2);
    check("hold.wr_data", {7'd0, wr_data}, 16'd77);
    @(posedge clk);
    #1;
    check("hold.we_e3", {15'd0, wr_en}, 16'd0);
    check("hold.ready_e3", {15'd0, instr_ready}, 16'd1);
    check("hold.busy_e3", {15'd0, busy}, 16'd0);
    check("hold.rf2", {7'd0, rf[2]}, 16'd77);
    instr_valid = 1'b0;
    @(posedge clk);
    #1;
    check("hold.busy_e4", {15'd0, busy}, 16'd0);
    check("hold.we_e4", {15'd0, wr_en}, 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
